des_sbox_seq: RTL and testbench

- Sequential DES S-box substitution stage: takes the 48-bit E-expanded, key-mixed half-block and produces the 32-bit S-box result.
- Sits directly upstream of the P permutation module and drives its data_in.
- Shares one configurable group of S-box lookups over several cycles, trading latency for area.
- Uses valid/ready handshakes on both sides so the iterative round controller can stall it.

---
 rtl/des_sbox_seq_if.sv | 19 +
 rtl/des_sbox_seq.sv | 105 ++++++++++
 tb/tb_des_sbox_seq.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/des_sbox_seq_if.sv
// rtl/des_sbox_seq_if.sv - valid/ready block-in, result-out bundle for the DES S-box stage
interface des_sbox_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [48:0] data_in;
   logic        out_valid;
   logic        out_ready;
   logic [32:0] data_out;

   modport master (
      output in_valid, data_in, out_ready,
      input  in_ready, out_valid, data_out
   );

   modport slave (
      input  in_valid, data_in, out_ready,
      output in_ready, out_valid, data_out
   );
endinterface

// File: rtl/des_sbox_seq.sv
// rtl/des_sbox_seq.sv - iterative DES S-box layer, BOXES_PER_CYCLE lookups per clock
module des_sbox_seq #(
   parameter int BOXES_PER_CYCLE = 1
) (
   input logic           clk,
   input logic           rst_n,
   des_sbox_seq_if.slave bus
);
   localparam int GROUPS = 8 / BOXES_PER_CYCLE;
   localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state;
   logic          in_ready_q;
   logic          out_valid_q;
   logic [CW-1:0] cnt;
   // MSB-first working copies: DES bit 1 sits at the top of each vector
   logic [47:0]   blk;
   logic [31:0]   res;
   logic [31:0]   res_next;
   logic [32:0]   data_des;
   logic [2:0]    first;
   logic          unused_bit0;

   function automatic logic [3:0] sbox(input logic [2:0] idx, input logic [5:0] x);
      logic [255:0] t;
      logic [5:0]   a;
      case (idx)
         3'd0:    t = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
         3'd1:    t = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
         3'd2:    t = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
         3'd3:    t = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
         3'd4:    t = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
         3'd5:    t = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
         3'd6:    t = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
         default: t = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
      endcase
      // row {b1,b6} selects the 16-entry line, column {b2..b5} the nibble within it
      a = {x[5], x[0], x[4:1]};
      return t[255 - 4*int'(a) -: 4];
   endfunction

   assign first       = 3'(int'(cnt) * BOXES_PER_CYCLE);
   assign unused_bit0 = bus.data_in[0];

   always_comb begin
      res_next = res;
      for (int j = 0; j < BOXES_PER_CYCLE; j++) begin
         res_next[31 - 4*(int'(first) + j) -: 4] =
            sbox(3'(int'(first) + j), blk[47 - 6*(int'(first) + j) -: 6]);
      end
   end

   always_comb begin
      data_des = '0;
      for (int k = 1; k <= 32; k++) data_des[k] = res[32-k];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         cnt         <= '0;
         blk         <= '0;
         res         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  for (int k = 1; k <= 48; k++) blk[48-k] <= bus.data_in[k];
                  cnt        <= '0;
                  in_ready_q <= 1'b0;
                  state      <= BUSY;
               end
            end
            BUSY: begin
               res <= res_next;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(GROUPS - 1)) begin
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               state       <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.data_out  = data_des;
endmodule

// File: tb/tb_des_sbox_seq.sv
// tb/tb_des_sbox_seq.sv - directed and reference-model bench for des_sbox_seq at 1/2/4/8 boxes per cycle
module tb_des_sbox_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid;
   logic        out_ready;
   logic [48:0] data_in;

   int n_cmp = 0;
   int n_err = 0;

   logic        ov   [4];
   logic        ir   [4];
   logic [32:0] dout [4];

   int lat_exp [4] = '{8, 4, 2, 1};
   int bpc     [4] = '{1, 2, 4, 8};

   // standard DES S-boxes, row-major (row*16 + column)
   int sb [0:7][0:63] = '{
      '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
      '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
      '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
      '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
      '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
      '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
      '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
      '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
   };

   des_sbox_seq_if if1 ();
   des_sbox_seq_if if2 ();
   des_sbox_seq_if if4 ();
   des_sbox_seq_if if8 ();

   des_sbox_seq #(.BOXES_PER_CYCLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
   des_sbox_seq #(.BOXES_PER_CYCLE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
   des_sbox_seq #(.BOXES_PER_CYCLE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
   des_sbox_seq #(.BOXES_PER_CYCLE(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

   assign if1.in_valid = in_valid;  assign if1.data_in = data_in;  assign if1.out_ready = out_ready;
   assign if2.in_valid = in_valid;  assign if2.data_in = data_in;  assign if2.out_ready = out_ready;
   assign if4.in_valid = in_valid;  assign if4.data_in = data_in;  assign if4.out_ready = out_ready;
   assign if8.in_valid = in_valid;  assign if8.data_in = data_in;  assign if8.out_ready = out_ready;

   assign ov[0] = if1.out_valid;  assign ir[0] = if1.in_ready;  assign dout[0] = if1.data_out;
   assign ov[1] = if2.out_valid;  assign ir[1] = if2.in_ready;  assign dout[1] = if2.data_out;
   assign ov[2] = if4.out_valid;  assign ir[2] = if4.in_ready;  assign dout[2] = if4.data_out;
   assign ov[3] = if8.out_valid;  assign ir[3] = if8.in_ready;  assign dout[3] = if8.data_out;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // DES bit 1 ends up as the leftmost hex digit, matching textbook notation
   function automatic logic [31:0] des_order(input logic [32:0] d);
      logic [31:0] r;
      for (int k = 1; k <= 32; k++) r[32-k] = d[k];
      return r;
   endfunction

   function automatic logic [32:1] ref_s(input logic [48:1] d);
      logic [32:1] r;
      int row, col, v;
      for (int i = 0; i < 8; i++) begin
         row = 2*int'(d[6*i+1]) + int'(d[6*i+6]);
         col = 8*int'(d[6*i+2]) + 4*int'(d[6*i+3]) + 2*int'(d[6*i+4]) + int'(d[6*i+5]);
         v = sb[i][16*row + col];
         for (int b = 0; b < 4; b++) r[4*i+1+b] = v[3-b];
      end
      return r;
   endfunction

   task automatic issue(input logic [48:1] d);
      chk("issue_in_ready", ir[0], 1'b1);
      in_valid = 1'b1;
      data_in  = {d, 1'b0};
      @(posedge clk); #1;
      in_valid = 1'b0;
      data_in  = ~data_in;
   endtask

   task automatic collect(input string tag, input logic [31:0] exp_des);
      int          lat [4];
      logic [31:0] got [4];
      for (int i = 0; i < 4; i++) begin lat[i] = -1; got[i] = '0; end
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 4; i++) begin
            if (ov[i] && lat[i] < 0) begin
               lat[i] = c;
               got[i] = des_order(dout[i]);
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("%s_lat_bpc%0d", tag, bpc[i]), lat[i], lat_exp[i]);
         chk($sformatf("%s_data_bpc%0d", tag, bpc[i]), got[i], exp_des);
      end
   endtask

   task automatic run_b2b();
      logic [48:1] d;
      logic [32:1] q [$];
      logic [32:1] e;
      logic        acc;
      int cyc = 0, last_acc = -1, n_acc = 0, n_out = 0;
      d = {16'($urandom), 32'($urandom)};
      data_in  = {d, 1'b0};
      in_valid = 1'b1;
      while (n_out < 1000 && cyc < 15000) begin
         acc = in_valid && ir[0];
         @(posedge clk); #1;
         cyc++;
         if (acc) begin
            q.push_back(ref_s(d));
            if (last_acc >= 0) chk("b2b_gap", cyc - last_acc, 10);
            last_acc = cyc;
            n_acc++;
            d = {16'($urandom), 32'($urandom)};
            data_in = {d, 1'b0};
            if (n_acc == 1000) in_valid = 1'b0;
         end
         if (ov[0]) begin
            if (q.size() == 0) chk("b2b_spurious_valid", 1'b1, 1'b0);
            else begin
               e = q.pop_front();
               chk("b2b_data", dout[0][32:1], e);
            end
            n_out++;
         end
      end
      in_valid = 1'b0;
      chk("b2b_result_count", n_out, 1000);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      logic [48:1] d;
      int pulses;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      data_in   = '0;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_in_ready", ir[0], 1'b1);
      chk("rst_out_valid", ov[0], 1'b0);
      chk("rst_data_out", dout[0], 33'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_in_ready", ir[0], 1'b1);
      chk("post_rst_out_valid", ov[3], 1'b0);

      issue('0);
      collect("zeros", 32'hEFA72C4D);
      issue('1);
      collect("ones", 32'hD9CE3DCB);
      d = '0; d[1] = 1'b1;
      issue(d);
      collect("s1_row2", 32'h4FA72C4D);
      d = '0; d[6] = 1'b1;
      issue(d);
      collect("s1_row1", 32'h0FA72C4D);
      d = '0; d[2] = 1'b1; d[3] = 1'b1; d[4] = 1'b1; d[5] = 1'b1;
      issue(d);
      collect("s1_col15", 32'h7FA72C4D);
      chk("bit0_zero", dout[0][0], 1'b0);

      // downstream stall while DONE
      out_ready = 1'b0;
      issue('0);
      for (int c = 0; c < 12 && !ov[0]; c++) begin @(posedge clk); #1; end
      chk("bp_valid", ov[0], 1'b1);
      for (int c = 0; c < 20; c++) begin
         if (c == 10) begin in_valid = 1'b1; data_in = {48'hFFFF_FFFF_FFFF, 1'b0}; end
         @(posedge clk); #1;
         in_valid = 1'b0;
         chk("bp_hold_valid", ov[0], 1'b1);
         chk("bp_hold_data", des_order(dout[0]), 32'hEFA72C4D);
         chk("bp_in_ready", ir[0], 1'b0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_valid", ov[0], 1'b0);
      chk("bp_release_ready", ir[0], 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("bp_stays_idle", ov[0], 1'b0);

      // asynchronous abort three cycles into BUSY
      issue('1);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_out_valid", ov[0], 1'b0);
      chk("abort_data_out", dout[0], 33'h0);
      chk("abort_in_ready", ir[0], 1'b1);
      chk("abort_data_out_bpc8", dout[3], 33'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (ov[0]) pulses++;
      end
      chk("abort_no_stale_valid", pulses, 0);
      issue('0);
      collect("after_abort", 32'hEFA72C4D);

      // in_valid already high as reset releases
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b1;
      d = '0; d[6] = 1'b1;
      data_in = {d, 1'b0};
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      data_in  = '0;
      collect("rst_release_accept", 32'h0FA72C4D);

      run_b2b();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
